fifo_uart_tx: RTL

//  Downstream drain stage for the 8-bit FIFO. Pops bytes while FIFO not Empty and serialises them on a

---
 rtl/fifo_uart_tx_pkg.sv | 23 ++
 rtl/fifo_uart_tx_if.sv | 23 ++
 rtl/fifo_uart_tx_baud_tick_gen.sv | 41 ++++
 rtl/fifo_uart_tx.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter and its
// companion blocks (the UART receiver reuses the state codes and line levels).
package fifo_uart_tx_pkg;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_BAUD_DIV   = 868;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // Line levels
  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  // Frame sequencer states, fixed 3-bit encodings
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } tx_state_e;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port as seen by a draining consumer. The consumer (master) issues
// the read strobe; the FIFO (slave) supplies Empty and the registered read data.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  rd_en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output rd_en,
    input  empty,
    input  rd_data
  );

  modport slave (
    input  rd_en,
    output empty,
    output rd_data
  );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each
// bit period. A clear restarts the period so every state begins aligned.
module fifo_uart_tx_baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Next count: restart on clear or at the end of a bit period
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a FIFO and sends each one as an 8N1 UART frame, LSB first.
// All outputs are registered; the read strobe is a single cycle and is only
// raised from IDLE when the FIFO reports data.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  fifo_uart_tx_if.master       fifo_rd,
  output logic                 txd_o,
  output logic                 busy_o,
  output logic [15:0]          tx_count_o
);

  localparam int            BW       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic                  txd_q, txd_d;
  logic                  rd_en_q, rd_en_d;
  logic                  busy_q, busy_d;
  logic [15:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;

  logic baud_clr;
  logic baud_tick;

  // The bit timer only runs in the timed states and restarts on every state
  // entry, so START/DATA/STOP each begin with a full bit period.
  assign baud_clr = (state_d != state_q) ||
                    !(state_q inside {S_START, S_DATA, S_STOP});

  fifo_uart_tx_baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (baud_clr),
    .tick_o (baud_tick)
  );

  // Frame sequencer: next state and next values of all registered outputs
  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    rd_en_d = rd_en_q;
    busy_d  = busy_q;
    count_d = count_q;
    shift_d = shift_q;
    bit_d   = bit_q;

    unique case (state_q)
      S_IDLE: begin
        txd_d = UART_IDLE;
        if (enable_i && !fifo_rd.empty) begin
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_READ;
        end
      end

      // FIFO presents the popped byte on the edge that leaves this state
      S_READ: begin
        rd_en_d = 1'b0;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d = fifo_rd.rd_data;
        txd_d   = UART_START;
        state_d = S_START;
      end

      S_START: begin
        if (baud_tick) begin
          txd_d   = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_q == LAST_BIT) begin
            txd_d   = UART_IDLE;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          count_d = count_q + 16'd1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = UART_IDLE;
        rd_en_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      txd_q   <= UART_IDLE;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  assign fifo_rd.rd_en = rd_en_q;
  assign txd_o         = txd_q;
  assign busy_o        = busy_q;
  assign tx_count_o    = count_q;

endmodule
